// File: rtl/cpu_boot_ctl_pkg.sv
// Shared types for the accumulator-CPU boot/run controller.
// Holds FSM state encodings and CPU bus width defaults.
package cpu_boot_ctl_pkg;

    localparam int CPU_ADDR_W = 13;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CRST    = 3'd2,
        ST_RUN     = 3'd3,
        ST_HALTED  = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    function automatic logic can_start(state_e s);
        return (s == ST_IDLE) || (s == ST_HALTED) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/cpu_boot_ctl_ld_cnt.sv
// Loader address / remaining-length counter for cpu_boot_ctl.
// Address wraps modulo 2^ADDR_W; last_o flags the final byte.
module boot_ld_cnt
    import cpu_boot_ctl_pkg::*;
#(
    parameter int                 ADDR_W    = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0]  LOAD_BASE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;

    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        if (load_i) begin
            addr_d = LOAD_BASE;
            len_d  = len_i;
        end else if (step_i) begin
            addr_d = addr_q + 1'b1;
            len_d  = len_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            addr_q <= addr_d;
            len_q  <= len_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (len_q == ADDR_W'(1));

endmodule

// File: rtl/cpu_boot_ctl.sv
// Boot/run controller: loads a program image into RAM, resets and runs the CPU.
// Optional run watchdog enabled by defining CPU_WDOG_EN.
module cpu_boot_ctl
    import cpu_boot_ctl_pkg::*;
#(
    parameter int                ADDR_W    = CPU_ADDR_W,
    parameter int                DATA_W    = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
    parameter int                RST_CYC   = 4,
    parameter int                CNT_W     = 20,
    parameter logic [CNT_W-1:0]  TIMEOUT   = {CNT_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              timeout
);

`ifdef CPU_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    localparam int              RCW     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0]  RC_LAST = RCW'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LIM = TIMEOUT - 1'b1;

    state_e            state_q, state_d;
    logic [RCW-1:0]    rc_q, rc_d;
    logic [CNT_W-1:0]  rcyc_q, rcyc_d;
    logic              ld_load;
    logic              ld_step;
    logic              ld_last;
    logic [ADDR_W-1:0] ld_addr;
    logic              wd_hit;

    boot_ld_cnt #(
        .ADDR_W    (ADDR_W),
        .LOAD_BASE (LOAD_BASE)
    ) u_ld_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (ld_load),
        .len_i  (load_len),
        .step_i (ld_step),
        .addr_o (ld_addr),
        .last_o (ld_last)
    );

    assign ld_step = (state_q == ST_LOAD) && in_valid;
    assign wd_hit  = WDOG_ON && (rcyc_q == WD_LIM);

    always_comb begin
        state_d = state_q;
        rc_d    = '0;
        rcyc_d  = rcyc_q;
        ld_load = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                    if (start) begin
                        rcyc_d = '0;
                        if (load_len != '0) begin
                            state_d = ST_LOAD;
                            ld_load = 1'b1;
                        end else begin
                            state_d = ST_CRST;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid && ld_last) begin
                        state_d = ST_CRST;
                    end
                end
                ST_CRST: begin
                    if (rc_q == RC_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rcyc_q != {CNT_W{1'b1}}) begin
                        rcyc_d = rcyc_q + 1'b1;
                    end
                    // halt in the watchdog limit cycle still counts as a clean halt
                    if (cpu_halt) begin
                        state_d = ST_HALTED;
                    end else if (wd_hit) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            rcyc_q  <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            rcyc_q  <= rcyc_d;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        cpu_rst   = 1'b1;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            ST_LOAD: begin
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_addr  = ld_addr;
                mem_wdata = in_data;
            end
            ST_RUN: begin
                cpu_rst   = 1'b0;
                mem_rd    = cpu_rd;
                mem_we    = cpu_wr;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            ST_HALTED: cpu_rst = 1'b0;
            default: ;
        endcase
    end

    assign busy       = !can_start(state_q);
    assign done       = (state_q == ST_HALTED);
    assign timeout    = (state_q == ST_TIMEOUT);
    assign run_cycles = rcyc_q;

endmodule

// File: tb/tb_cpu_boot_ctl.sv
// Directed self-checking bench for cpu_boot_ctl.
// Watchdog scenario exercised when CPU_WDOG_EN is defined.
module tb_cpu_boot_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] load_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        cpu_halt = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;

    logic        a_in_ready, a_cpu_rst, a_mem_rd, a_mem_we;
    logic [12:0] a_mem_addr;
    logic [7:0]  a_mem_wdata;
    logic        a_busy, a_done, a_timeout;
    logic [19:0] a_run_cycles;

    logic        w_in_ready, w_cpu_rst, w_mem_rd, w_mem_we;
    logic [12:0] w_mem_addr;
    logic [7:0]  w_mem_wdata;
    logic        w_busy, w_done, w_timeout;
    logic [19:0] w_run_cycles;

    int vec = 0;
    int miss = 0;

    always #5 clk = ~clk;

    cpu_boot_ctl u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load_len(load_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .cpu_rst(a_cpu_rst), .cpu_halt(cpu_halt),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .mem_rd(a_mem_rd), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .busy(a_busy),
        .done(a_done), .run_cycles(a_run_cycles), .timeout(a_timeout)
    );

    cpu_boot_ctl #(.LOAD_BASE(13'h1FFE)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load_len(load_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_in_ready), .cpu_rst(w_cpu_rst), .cpu_halt(cpu_halt),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .mem_rd(w_mem_rd), .mem_we(w_mem_we),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .busy(w_busy),
        .done(w_done), .run_cycles(w_run_cycles), .timeout(w_timeout)
    );

`ifdef CPU_WDOG_EN
    logic        d_in_ready, d_cpu_rst, d_mem_rd, d_mem_we;
    logic [12:0] d_mem_addr;
    logic [7:0]  d_mem_wdata;
    logic        d_busy, d_done, d_timeout;
    logic [4:0]  d_run_cycles;

    cpu_boot_ctl #(.CNT_W(5), .TIMEOUT(5'd20)) u_wd (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load_len(load_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_in_ready), .cpu_rst(d_cpu_rst), .cpu_halt(cpu_halt),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .mem_rd(d_mem_rd), .mem_we(d_mem_we),
        .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .busy(d_busy),
        .done(d_done), .run_cycles(d_run_cycles), .timeout(d_timeout)
    );
`endif

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; cpu_halt = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        load_len = '0; in_data = '0;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vec++;
        if ({a_cpu_rst, a_in_ready, a_mem_rd, a_mem_we, a_busy, a_done, a_timeout} !== 7'b1000000) begin
            miss++;
            $display("FAIL reset_flags: got %b want 1000000",
                {a_cpu_rst, a_in_ready, a_mem_rd, a_mem_we, a_busy, a_done, a_timeout});
        end
        vec++;
        if ({a_mem_addr, a_mem_wdata, a_run_cycles} !== 41'd0) begin
            miss++;
            $display("FAIL reset_bus: addr %h wdata %h cyc %h want 0", a_mem_addr, a_mem_wdata, a_run_cycles);
        end
    endtask

    // load A5,3C,FF with gaps, then 4 CRST cycles, ending at first RUN cycle
    task automatic test_load();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
        cyc();
        start = 1'b1; load_len = 13'd3;
        cyc();
        start = 1'b0; load_len = 13'd0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            #1;
            vec++;
            if ({a_in_ready, a_mem_we, a_cpu_rst} !== 3'b101) begin
                miss++;
                $display("FAIL load_gap%0d: rdy/we/rst %b want 101", i, {a_in_ready, a_mem_we, a_cpu_rst});
            end
            cyc();
            in_valid = 1'b1; in_data = bytes[i];
            #1;
            vec++;
            if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 13'(i), bytes[i]}) begin
                miss++;
                $display("FAIL load_byte%0d: we %b addr %h data %h want 1 %h %h",
                    i, a_mem_we, a_mem_addr, a_mem_wdata, i, bytes[i]);
            end
            cyc();
        end
        in_valid = 1'b0;
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h155; cpu_wdata = 8'h77;
        for (int k = 0; k < 4; k++) begin
            #1;
            vec++;
            if ({a_cpu_rst, a_busy, a_in_ready, a_mem_rd, a_mem_we, a_mem_addr, a_mem_wdata} !==
                {5'b11000, 13'd0, 8'd0}) begin
                miss++;
                $display("FAIL crst%0d: rst/busy/rdy/rd/we %b addr %h want 11000 0",
                    k, {a_cpu_rst, a_busy, a_in_ready, a_mem_rd, a_mem_we}, a_mem_addr);
            end
            cyc();
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #1;
        vec++;
        if ({a_cpu_rst, a_busy} !== 2'b01) begin
            miss++;
            $display("FAIL run_entry: rst/busy %b want 01", {a_cpu_rst, a_busy});
        end
    endtask

    // continues from the first RUN cycle; halt on the 10th
    task automatic test_run_halt();
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) cyc();
            cpu_halt = (i == 10);
            cpu_rd = (i == 3); cpu_wr = (i == 3);
            cpu_addr = (i == 3) ? 13'h0ABC : 13'h0;
            cpu_wdata = (i == 3) ? 8'h5A : 8'h0;
            #1;
            if (i == 3) begin
                vec++;
                if ({a_mem_rd, a_mem_we, a_mem_addr, a_mem_wdata} !== {2'b11, 13'h0ABC, 8'h5A}) begin
                    miss++;
                    $display("FAIL run_pass: rd/we %b addr %h data %h want 11 0abc 5a",
                        {a_mem_rd, a_mem_we}, a_mem_addr, a_mem_wdata);
                end
            end
            if (i == 5) begin
                vec++;
                if (a_run_cycles !== 20'd4) begin
                    miss++;
                    $display("FAIL run_count: got %0d want 4", a_run_cycles);
                end
            end
        end
        cyc();
        cpu_halt = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h0123;
        #1;
        vec++;
        if ({a_done, a_busy, a_cpu_rst, a_mem_rd, a_mem_we, a_mem_addr} !== {5'b10000, 13'd0}) begin
            miss++;
            $display("FAIL halted: done/busy/rst/rd/we %b addr %h want 10000 0",
                {a_done, a_busy, a_cpu_rst, a_mem_rd, a_mem_we}, a_mem_addr);
        end
        vec++;
        if (a_run_cycles !== 20'd10) begin
            miss++;
            $display("FAIL halt_cycles: got %0d want 10", a_run_cycles);
        end
        cyc(); cyc();
        #1;
        vec++;
        if (a_run_cycles !== 20'd10) begin
            miss++;
            $display("FAIL cycles_frozen: got %0d want 10", a_run_cycles);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    endtask

    task automatic test_wrap();
        logic [12:0] exp [4];
        exp[0] = 13'h1FFE; exp[1] = 13'h1FFF; exp[2] = 13'h0000; exp[3] = 13'h0001;
        do_reset();
        start = 1'b1; load_len = 13'd4;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h40 + i);
            #1;
            vec++;
            if ({w_mem_we, w_mem_addr, w_mem_wdata} !== {1'b1, exp[i], 8'(8'h40 + i)}) begin
                miss++;
                $display("FAIL wrap%0d: we %b addr %h data %h want 1 %h %h",
                    i, w_mem_we, w_mem_addr, w_mem_wdata, exp[i], 8'(8'h40 + i));
            end
            cyc();
        end
        in_valid = 1'b0;
        #1;
        vec++;
        if ({w_in_ready, w_busy, w_cpu_rst} !== 3'b011) begin
            miss++;
            $display("FAIL wrap_crst: rdy/busy/rst %b want 011", {w_in_ready, w_busy, w_cpu_rst});
        end
    endtask

    task automatic test_abort();
        do_reset();
        start = 1'b1; load_len = 13'd5;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        cyc();
        in_valid = 1'b0;
        abort = 1'b1; start = 1'b1; load_len = 13'd5;
        cyc();
        abort = 1'b0; start = 1'b0;
        #1;
        vec++;
        if ({a_in_ready, a_cpu_rst, a_busy} !== 3'b010) begin
            miss++;
            $display("FAIL abort_idle: rdy/rst/busy %b want 010", {a_in_ready, a_cpu_rst, a_busy});
        end
        cyc();
        start = 1'b1; load_len = 13'd2;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h22;
        #1;
        vec++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 13'd0, 8'h22}) begin
            miss++;
            $display("FAIL abort_restart: we %b addr %h data %h want 1 0000 22",
                a_mem_we, a_mem_addr, a_mem_wdata);
        end
        cyc();
        in_valid = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        #1;
        vec++;
        if ({a_busy, a_in_ready} !== 2'b00) begin
            miss++;
            $display("FAIL abort_load2: busy/rdy %b want 00", {a_busy, a_in_ready});
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        start = 1'b1; load_len = 13'd0;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h99;
        #1;
        vec++;
        if ({a_busy, a_in_ready, a_mem_we, a_cpu_rst} !== 4'b1001) begin
            miss++;
            $display("FAIL zero_len: busy/rdy/we/rst %b want 1001",
                {a_busy, a_in_ready, a_mem_we, a_cpu_rst});
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        #1;
        vec++;
        if (a_cpu_rst !== 1'b0) begin
            miss++;
            $display("FAIL zero_run: cpu_rst %b want 0", a_cpu_rst);
        end
        start = 1'b1; load_len = 13'd3;
        cyc();
        start = 1'b0;
        #1;
        vec++;
        if ({a_cpu_rst, a_in_ready, a_busy, a_run_cycles} !== {3'b001, 20'd1}) begin
            miss++;
            $display("FAIL start_in_run: rst/rdy/busy %b cycles %0d want 001 1",
                {a_cpu_rst, a_in_ready, a_busy}, a_run_cycles);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        start = 1'b1; load_len = 13'd0;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        repeat (19) cyc();
        #1;
`ifdef CPU_WDOG_EN
        vec++;
        if ({d_cpu_rst, d_timeout, d_run_cycles} !== {2'b00, 5'd19}) begin
            miss++;
            $display("FAIL wd_limit_cycle: rst/to %b cycles %0d want 00 19",
                {d_cpu_rst, d_timeout}, d_run_cycles);
        end
        cyc();
        #1;
        vec++;
        if ({d_timeout, d_cpu_rst, d_busy, d_done, d_run_cycles} !== {4'b1100, 5'd20}) begin
            miss++;
            $display("FAIL wd_timeout: to/rst/busy/done %b cycles %0d want 1100 20",
                {d_timeout, d_cpu_rst, d_busy, d_done}, d_run_cycles);
        end
        start = 1'b1; load_len = 13'd0;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        repeat (19) cyc();
        cpu_halt = 1'b1;
        cyc();
        cpu_halt = 1'b0;
        #1;
        vec++;
        if ({d_done, d_timeout, d_cpu_rst, d_run_cycles} !== {3'b100, 5'd20}) begin
            miss++;
            $display("FAIL wd_halt_wins: done/to/rst %b cycles %0d want 100 20",
                {d_done, d_timeout, d_cpu_rst}, d_run_cycles);
        end
`else
        repeat (6) cyc();
        #1;
        vec++;
        if ({a_timeout, a_cpu_rst, a_busy, a_run_cycles} !== {3'b001, 20'd25}) begin
            miss++;
            $display("FAIL no_wdog: to/rst/busy %b cycles %0d want 001 25",
                {a_timeout, a_cpu_rst, a_busy}, a_run_cycles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_halt();
        test_wrap();
        test_abort();
        test_zero_len();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
